// File: rtl/transpose_pkg.sv
// transpose_pkg: shared sizing helpers and default-configuration types for the
// matrix-transpose switch network and its output-side row drain.
//   chunk_width() - CHUNK_WIDTH derived from DATA_WIDTH, NUM_PE and NUM_MG
//   idx_width()   - width of a row index, clog2(NUM_PE)
//   chunk_t/row_t/mat_t - element types for the default configuration
package transpose_pkg;

    function automatic int chunk_width(int data_width, int num_pe, int num_mg);
        return num_mg / num_pe * data_width;
    endfunction

    function automatic int idx_width(int num_pe);
        return (num_pe > 1) ? $clog2(num_pe) : 1;
    endfunction

    localparam int DEF_DATA_WIDTH  = 64;
    localparam int DEF_NUM_PE      = 8;
    localparam int DEF_NUM_MG      = 8;
    localparam int DEF_CHUNK_WIDTH = chunk_width(DEF_DATA_WIDTH, DEF_NUM_PE, DEF_NUM_MG);
    localparam int DEF_IDX_W       = idx_width(DEF_NUM_PE);

    typedef logic [DEF_CHUNK_WIDTH-1:0] chunk_t;
    typedef chunk_t [DEF_NUM_PE-1:0]    row_t;
    typedef row_t   [DEF_NUM_PE-1:0]    mat_t;

endpackage

// File: rtl/transpose_drain_bank.sv
// transpose_drain_bank: one NUM_PE x NUM_PE chunk matrix store.
//   clk   - clock
//   ld_i  - load enable; mat_i is written into the store on this edge
//   mat_i - matrix to store, indexed [row][chunk]
//   sel_i - row select for the read port
//   row_o - chunks of the selected row (combinational read)
// The store has no reset: contents are only meaningful once loaded.
module transpose_drain_bank #(
    parameter int NUM_PE      = 8,
    parameter int CHUNK_WIDTH = 64,
    parameter int IDX_W       = 3
) (
    input  logic                                        clk,
    input  logic                                        ld_i,
    input  logic [NUM_PE-1:0][NUM_PE-1:0][CHUNK_WIDTH-1:0] mat_i,
    input  logic [IDX_W-1:0]                            sel_i,
    output logic [NUM_PE-1:0][CHUNK_WIDTH-1:0]          row_o
);

    logic [NUM_PE-1:0][NUM_PE-1:0][CHUNK_WIDTH-1:0] mat_q;

    always_ff @(posedge clk) begin
        if (ld_i) begin
            mat_q <= mat_i;
        end
    end

    assign row_o = mat_q[sel_i];

endmodule

// File: rtl/transpose_row_drain.sv
// transpose_row_drain: captures a full matrix from the transpose switch on its
// one-cycle valid pulse and streams it out a row per valid/ready handshake.
// Two ping-pong banks let one matrix be captured while the other drains.
//   clk, rst   - clock, synchronous active-high reset
//   mat_in     - matrix from switch [row][chunk]; mat_val marks it valid
//   can_accept - a bank is free, so a mat_val now will be captured
//   row_out    - chunks of row row_idx of the draining matrix
//   row_last   - row_idx is the final row of the matrix
//   row_val    - row_out valid; row_rdy - consumer takes the row
//   overflow   - sticky: a matrix arrived with no free bank and was dropped
//   mat_done   - wrapping count of fully drained matrices
module transpose_row_drain
    import transpose_pkg::*;
#(
    parameter  int DATA_WIDTH  = 64,
    parameter  int NUM_PE      = 8,
    parameter  int NUM_MG      = 8,
    localparam int CHUNK_WIDTH = chunk_width(DATA_WIDTH, NUM_PE, NUM_MG),
    localparam int IDX_W       = idx_width(NUM_PE)
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [NUM_PE-1:0][NUM_PE-1:0][CHUNK_WIDTH-1:0] mat_in,
    input  logic                                           mat_val,
    output logic                                           can_accept,
    output logic [NUM_PE-1:0][CHUNK_WIDTH-1:0]             row_out,
    output logic [IDX_W-1:0]                               row_idx,
    output logic                                           row_last,
    output logic                                           row_val,
    input  logic                                           row_rdy,
    output logic                                           overflow,
    output logic [15:0]                                    mat_done
);

    logic [1:0]       full_q, full_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0] row_cnt_q, row_cnt_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      mat_done_q, mat_done_d;

    logic [1:0][NUM_PE-1:0][CHUNK_WIDTH-1:0] bank_row;
    logic capture, hs, last;

    // Accept decision looks only at registered state, so a bank released in
    // this same cycle is not yet visible as free.
    assign can_accept = !full_q[wr_ptr_q];
    assign capture    = mat_val && can_accept;
    assign row_val    = full_q[rd_ptr_q];
    assign last       = (row_cnt_q == IDX_W'(NUM_PE - 1));
    assign hs         = row_val && row_rdy;

    // A bank only loads when it is empty, so full banks are never disturbed.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        transpose_drain_bank #(
            .NUM_PE     (NUM_PE),
            .CHUNK_WIDTH(CHUNK_WIDTH),
            .IDX_W      (IDX_W)
        ) u_bank (
            .clk  (clk),
            .ld_i (capture && (wr_ptr_q == 1'(b))),
            .mat_i(mat_in),
            .sel_i(row_cnt_q),
            .row_o(bank_row[b])
        );
    end

    assign row_out  = bank_row[rd_ptr_q];
    assign row_idx  = row_cnt_q;
    assign row_last = last;
    assign overflow = overflow_q;
    assign mat_done = mat_done_q;

    always_comb begin
        full_d     = full_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        row_cnt_d  = row_cnt_q;
        overflow_d = overflow_q;
        mat_done_d = mat_done_q;

        // Capture targets an empty bank and release a full one, so when both
        // happen in one cycle they always touch different banks.
        if (capture) begin
            full_d[wr_ptr_q] = 1'b1;
            wr_ptr_d         = !wr_ptr_q;
        end
        if (mat_val && !can_accept) begin
            overflow_d = 1'b1;
        end

        if (hs) begin
            if (last) begin
                row_cnt_d        = '0;
                full_d[rd_ptr_q] = 1'b0;
                rd_ptr_d         = !rd_ptr_q;
                mat_done_d       = mat_done_q + 16'd1;
            end else begin
                row_cnt_d = row_cnt_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q     <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            row_cnt_q  <= '0;
            overflow_q <= 1'b0;
            mat_done_q <= '0;
        end else begin
            full_q     <= full_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            row_cnt_q  <= row_cnt_d;
            overflow_q <= overflow_d;
            mat_done_q <= mat_done_d;
        end
    end

endmodule

// File: tb/tb_transpose_row_drain.sv
// Bench for transpose_row_drain: a queue-of-matrices model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_transpose_row_drain;
    localparam int DW  = 64;
    localparam int NPE = 8;
    localparam int NMG = 8;
    localparam int CW  = NMG / NPE * DW;

    typedef logic [NPE-1:0][NPE-1:0][CW-1:0] mat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    mat_t mat_in = '0;
    logic mat_val = 1'b0;
    logic row_rdy = 1'b0;
    logic can_accept, row_last, row_val, overflow;
    logic [NPE-1:0][CW-1:0] row_out;
    logic [$clog2(NPE)-1:0] row_idx;
    logic [15:0] mat_done;

    always #5 clk = ~clk;

    transpose_row_drain #(.DATA_WIDTH(DW), .NUM_PE(NPE), .NUM_MG(NMG)) dut (
        .clk(clk), .rst(rst), .mat_in(mat_in), .mat_val(mat_val),
        .can_accept(can_accept), .row_out(row_out), .row_idx(row_idx),
        .row_last(row_last), .row_val(row_val), .row_rdy(row_rdy),
        .overflow(overflow), .mat_done(mat_done)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic mat_t gen(int base);
        mat_t m;
        for (int r = 0; r < NPE; r++)
            for (int c = 0; c < NPE; c++)
                m[r][c] = CW'(base + r * NPE + c);
        return m;
    endfunction

    // Model: up to two pending matrices, draining front-first, one row per
    // handshake.
    mat_t mq[$];
    int   m_row  = 0;
    bit   m_ovf  = 0;
    int   m_done = 0;
    bit   chk_en = 0;

    always @(posedge clk) begin : model_upd
        bit acc;
        if (rst) begin
            mq.delete();
            m_row  = 0;
            m_ovf  = 0;
            m_done = 0;
        end else begin
            acc = (mq.size() < 2);
            if (mq.size() > 0 && row_rdy) begin
                m_row++;
                if (m_row == NPE) begin
                    void'(mq.pop_front());
                    m_row  = 0;
                    m_done = (m_done + 1) % 65536;
                end
            end
            if (mat_val) begin
                if (acc) mq.push_back(mat_in);
                else     m_ovf = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("can_accept", 64'(can_accept), 64'(mq.size() < 2));
            chk("row_val",    64'(row_val),    64'(mq.size() > 0));
            chk("row_idx",    64'(row_idx),    64'(m_row));
            chk("row_last",   64'(row_last),   64'(m_row == NPE - 1));
            chk("overflow",   64'(overflow),   64'(m_ovf));
            chk("mat_done",   64'(mat_done),   64'(m_done));
            if (mq.size() > 0) begin
                n_chk++;
                if (row_out !== mq[0][m_row]) begin
                    n_fail++;
                    $display("FAIL row_out: got %h expected %h", row_out, mq[0][m_row]);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; mat_val = 1'b0; row_rdy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int rows, hs, n;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1;
        chk("rst_row_val",    64'(row_val),    0);
        chk("rst_can_accept", 64'(can_accept), 1);
        chk("rst_row_idx",    64'(row_idx),    0);
        chk("rst_row_last",   64'(row_last),   0);
        chk("rst_overflow",   64'(overflow),   0);
        chk("rst_mat_done",   64'(mat_done),   0);

        // Single matrix, consumer always ready.
        mat_in = gen(0); mat_val = 1'b1; row_rdy = 1'b1;
        @(negedge clk);
        mat_val = 1'b0;
        chk("t1_first_val", 64'(row_val), 1);
        chk("t1_first_idx", 64'(row_idx), 0);
        chk("t1_r0c5",      64'(row_out[5]), 5);
        rows = 0;
        for (int i = 0; i < 12; i++) begin
            if (row_val) begin
                rows++;
                chk("t1_last", 64'(row_last), 64'(i == 7));
            end
            if (i == 2) chk("t1_r2c3", 64'(row_out[3]), 19);
            @(negedge clk);
        end
        chk("t1_rows", 64'(rows), 8);
        chk("t1_done", 64'(mat_done), 1);

        // Back-to-back matrices, 8 cycles apart, no bubble.
        do_reset();
        row_rdy = 1'b1; rows = 0;
        for (int i = 0; i < 30; i++) begin
            if (i >= 1 && i <= 24 && row_val) rows++;
            mat_val = (i % 8 == 0) && (i < 24);
            mat_in  = gen(100 * (i / 8 + 1));
            @(negedge clk);
        end
        mat_val = 1'b0;
        chk("t2_contig_rows", 64'(rows), 24);
        chk("t2_overflow",    64'(overflow), 0);
        chk("t2_done",        64'(mat_done), 3);

        // Backpressure, ready pattern 1,0,0,1.
        do_reset();
        hs = 0;
        for (int i = 0; i < 40; i++) begin
            row_rdy = (i % 4 == 0) || (i % 4 == 3);
            if (row_val && row_rdy) hs++;
            mat_val = (i == 0) || (i == 2);
            mat_in  = gen(1000 + i * 64);
            @(negedge clk);
        end
        mat_val = 1'b0;
        chk("t3_handshakes", 64'(hs), 16);
        chk("t3_done",       64'(mat_done), 2);

        // Overflow: third matrix dropped while stalled.
        do_reset();
        row_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) chk("t4_can_accept", 64'(can_accept), 0);
            mat_val = 1'b1;
            mat_in  = gen(2000 + i * 64);
            @(negedge clk);
        end
        mat_val = 1'b0;
        chk("t4_overflow", 64'(overflow), 1);
        row_rdy = 1'b1; hs = 0;
        for (int i = 0; i < 20; i++) begin
            if (row_val) hs++;
            @(negedge clk);
        end
        chk("t4_rows", 64'(hs), 16);
        chk("t4_done", 64'(mat_done), 2);

        // Release/capture collision on the last row.
        do_reset();
        row_rdy = 1'b0;
        mat_val = 1'b1; mat_in = gen(3000);
        @(negedge clk);
        mat_in = gen(3500);
        @(negedge clk);
        mat_val = 1'b0; row_rdy = 1'b1; n = 0;
        while (row_idx != 7 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reach_last", 64'(row_idx), 7);
        chk("t5_full_both", 64'(can_accept), 0);
        mat_val = 1'b1; mat_in = gen(4000);
        @(negedge clk);
        chk("t5_dropped_ovf", 64'(overflow), 1);
        chk("t5_freed", 64'(can_accept), 1);
        chk("t5_done1", 64'(mat_done), 1);
        mat_in = gen(4500);
        @(negedge clk);
        mat_val = 1'b0;
        chk("t5_recaptured", 64'(can_accept), 0);
        repeat (20) @(negedge clk);
        chk("t5_done3", 64'(mat_done), 3);

        // Reset mid-drain of the second matrix.
        do_reset();
        row_rdy = 1'b1;
        mat_val = 1'b1; mat_in = gen(5000);
        @(negedge clk);
        mat_in = gen(6000);
        @(negedge clk);
        mat_val = 1'b0; n = 0;
        while (!(mat_done == 16'd1 && row_idx == 4) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t6_reach_row4", 64'(row_idx), 4);
        rst = 1'b1; mat_val = 1'b1; mat_in = gen(7000);
        @(negedge clk);
        rst = 1'b0; mat_val = 1'b0;
        chk("t6_row_val", 64'(row_val), 0);
        chk("t6_can_accept", 64'(can_accept), 1);
        chk("t6_done", 64'(mat_done), 0);
        chk("t6_overflow", 64'(overflow), 0);
        mat_val = 1'b1; mat_in = gen(8000);
        @(negedge clk);
        mat_val = 1'b0;
        chk("t6_fresh_idx", 64'(row_idx), 0);
        chk("t6_fresh_r0c0", 64'(row_out[0]), 8000);
        repeat (10) @(negedge clk);
        chk("t6_fresh_done", 64'(mat_done), 1);

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
